// File: rtl/song_transport_if.sv
// Command, configuration and status bundle between a transport master and
// song_transport_ctrl.
interface song_transport_if #(
  parameter int TICK_DIV_W = 20,
  parameter int SONG_LEN_W = 12
);
  logic                  i_play;
  logic                  i_pause;
  logic                  i_stop;
  logic                  i_cfg_we;
  logic [TICK_DIV_W-1:0] i_cfg_tick_div;
  logic [3:0]            i_cfg_note_ticks;
  logic [SONG_LEN_W-1:0] i_cfg_song_len;
  logic                  i_cfg_loop;
  logic                  o_tick_stb;
  logic                  o_note_stb;
  logic                  o_chan_rst;
  logic [1:0]            o_state;
  logic [SONG_LEN_W-1:0] o_note_pos;
  logic                  o_done;

  modport master (
    output i_play, i_pause, i_stop, i_cfg_we,
    output i_cfg_tick_div, i_cfg_note_ticks, i_cfg_song_len, i_cfg_loop,
    input  o_tick_stb, o_note_stb, o_chan_rst, o_state, o_note_pos, o_done
  );

  modport slave (
    input  i_play, i_pause, i_stop, i_cfg_we,
    input  i_cfg_tick_div, i_cfg_note_ticks, i_cfg_song_len, i_cfg_loop,
    output o_tick_stb, o_note_stb, o_chan_rst, o_state, o_note_pos, o_done
  );
endinterface

// File: rtl/song_transport_ctrl.sv
// Song transport controller: play/pause/stop sequencing, shared tick and note
// strobes for the channel sequencers, and song position / end-of-pass tracking.
module song_transport_ctrl #(
  parameter int TICK_DIV_W         = 20,
  parameter int DEFAULT_TICK_DIV   = 416666,
  parameter int DEFAULT_NOTE_TICKS = 7,
  parameter int SONG_LEN_W         = 12,
  parameter int DEFAULT_SONG_LEN   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  song_transport_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_START   = 2'd1,
    ST_PLAYING = 2'd2,
    ST_PAUSED  = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [TICK_DIV_W-1:0] tick_cnt_r, tick_cnt_nxt_s, cfg_tick_div_r;
  logic [3:0]            frame_cnt_r, frame_cnt_nxt_s, cfg_note_ticks_r;
  logic [SONG_LEN_W-1:0] note_pos_r, note_pos_nxt_s, cfg_song_len_r;
  logic                  cfg_loop_r;
  logic                  tick_stb_r, tick_stb_nxt_s;
  logic                  note_stb_r, note_stb_nxt_s;
  logic                  done_r, done_nxt_s;
  logic                  chan_rst_r;
  logic                  end_of_pass_s;

  assign end_of_pass_s = (cfg_song_len_r != SONG_LEN_W'(0)) &&
                         (note_pos_r == cfg_song_len_r - SONG_LEN_W'(1));

  // Next-state, counter and strobe decode; stop dominates play, play dominates pause
  always_comb begin
    state_nxt_s     = state_r;
    tick_cnt_nxt_s  = tick_cnt_r;
    frame_cnt_nxt_s = frame_cnt_r;
    note_pos_nxt_s  = note_pos_r;
    tick_stb_nxt_s  = 1'b0;
    note_stb_nxt_s  = 1'b0;
    done_nxt_s      = 1'b0;
    case (state_r)
      ST_STOPPED: begin
        tick_cnt_nxt_s  = TICK_DIV_W'(0);
        frame_cnt_nxt_s = 4'd0;
        note_pos_nxt_s  = SONG_LEN_W'(0);
        if (!bus.i_stop && bus.i_play) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_STOPPED;
        end
      end
      ST_START: begin
        tick_cnt_nxt_s  = TICK_DIV_W'(0);
        frame_cnt_nxt_s = 4'd0;
        note_pos_nxt_s  = SONG_LEN_W'(0);
        if (bus.i_stop) begin
          state_nxt_s = ST_STOPPED;
        end else begin
          state_nxt_s = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (bus.i_stop) begin
          state_nxt_s     = ST_STOPPED;
          tick_cnt_nxt_s  = TICK_DIV_W'(0);
          frame_cnt_nxt_s = 4'd0;
          note_pos_nxt_s  = SONG_LEN_W'(0);
        end else if (bus.i_pause) begin
          state_nxt_s = ST_PAUSED;
        end else if (tick_cnt_r == cfg_tick_div_r) begin
          tick_cnt_nxt_s = TICK_DIV_W'(0);
          tick_stb_nxt_s = 1'b1;
          if (frame_cnt_r == cfg_note_ticks_r) begin
            frame_cnt_nxt_s = 4'd0;
            note_stb_nxt_s  = 1'b1;
            if (end_of_pass_s) begin
              note_pos_nxt_s = SONG_LEN_W'(0);
              done_nxt_s     = 1'b1;
              if (cfg_loop_r) begin
                state_nxt_s = ST_PLAYING;
              end else begin
                state_nxt_s = ST_STOPPED;
              end
            end else begin
              note_pos_nxt_s = note_pos_r + SONG_LEN_W'(1);
            end
          end else begin
            frame_cnt_nxt_s = frame_cnt_r + 4'd1;
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r + TICK_DIV_W'(1);
        end
      end
      ST_PAUSED: begin
        if (bus.i_stop) begin
          state_nxt_s     = ST_STOPPED;
          tick_cnt_nxt_s  = TICK_DIV_W'(0);
          frame_cnt_nxt_s = 4'd0;
          note_pos_nxt_s  = SONG_LEN_W'(0);
        end else if (bus.i_play) begin
          state_nxt_s = ST_PLAYING;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      default: begin
        state_nxt_s     = ST_STOPPED;
        tick_cnt_nxt_s  = TICK_DIV_W'(0);
        frame_cnt_nxt_s = 4'd0;
        note_pos_nxt_s  = SONG_LEN_W'(0);
      end
    endcase
  end

  // Transport state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_STOPPED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counters and output strobes; chan_rst is high for the whole START cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt_r  <= TICK_DIV_W'(0);
      frame_cnt_r <= 4'd0;
      note_pos_r  <= SONG_LEN_W'(0);
      tick_stb_r  <= 1'b0;
      note_stb_r  <= 1'b0;
      done_r      <= 1'b0;
      chan_rst_r  <= 1'b0;
    end else begin
      tick_cnt_r  <= tick_cnt_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      note_pos_r  <= note_pos_nxt_s;
      tick_stb_r  <= tick_stb_nxt_s;
      note_stb_r  <= note_stb_nxt_s;
      done_r      <= done_nxt_s;
      chan_rst_r  <= (state_nxt_s == ST_START);
    end
  end

  // Configuration is writable only while stopped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_tick_div_r   <= TICK_DIV_W'(DEFAULT_TICK_DIV);
      cfg_note_ticks_r <= 4'(DEFAULT_NOTE_TICKS);
      cfg_song_len_r   <= SONG_LEN_W'(DEFAULT_SONG_LEN);
      cfg_loop_r       <= 1'b1;
    end else if (bus.i_cfg_we && (state_r == ST_STOPPED)) begin
      cfg_tick_div_r   <= bus.i_cfg_tick_div;
      cfg_note_ticks_r <= bus.i_cfg_note_ticks;
      cfg_song_len_r   <= bus.i_cfg_song_len;
      cfg_loop_r       <= bus.i_cfg_loop;
    end else begin
      cfg_tick_div_r   <= cfg_tick_div_r;
      cfg_note_ticks_r <= cfg_note_ticks_r;
      cfg_song_len_r   <= cfg_song_len_r;
      cfg_loop_r       <= cfg_loop_r;
    end
  end

  assign bus.o_tick_stb = tick_stb_r;
  assign bus.o_note_stb = note_stb_r;
  assign bus.o_chan_rst = chan_rst_r;
  assign bus.o_state    = state_r;
  assign bus.o_note_pos = note_pos_r;
  assign bus.o_done     = done_r;

endmodule

// File: tb/tb_song_transport_ctrl.sv
// Scoreboard bench for song_transport_ctrl: a position-from-elapsed-cycles
// reference model predicts every cycle's outputs; a monitor compares them.
module tb_song_transport_ctrl;

  logic clk;
  logic rst_n;

  song_transport_if #(.TICK_DIV_W(20), .SONG_LEN_W(12)) bus ();

  song_transport_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb_q[$];

  // Reference model: playback position is derived from the number of
  // advancing cycles since START, not from cascaded counters.
  int     m_st;
  longint m_adv;
  int     m_div, m_nt, m_len;
  bit     m_loop;

  task automatic model_reset();
    m_st = 0; m_adv = 0;
    m_div = 416666; m_nt = 7; m_len = 0; m_loop = 1'b1;
  endtask

  task automatic model_step(input bit play, input bit pause, input bit stop,
                            input bit we, input int div, input int nt,
                            input int len, input bit loop,
                            output logic [17:0] e);
    bit tk = 1'b0, ns = 1'b0, dn = 1'b0;
    int nxt = m_st;
    longint ticks, notes, pos;
    case (m_st)
      0: begin
        if (we) begin m_div = div; m_nt = nt; m_len = len; m_loop = loop; end
        if (!stop && play) nxt = 1;
      end
      1: begin m_adv = 0; nxt = stop ? 0 : 2; end
      2: begin
        if (stop) begin nxt = 0; m_adv = 0; end
        else if (pause) nxt = 3;
        else begin
          m_adv++;
          if (m_adv % (m_div + 1) == 0) begin
            tk = 1'b1;
            ticks = m_adv / (m_div + 1);
            if (ticks % (m_nt + 1) == 0) begin
              ns = 1'b1;
              notes = ticks / (m_nt + 1);
              if (m_len != 0 && notes % m_len == 0) begin
                dn = 1'b1;
                if (!m_loop) begin nxt = 0; m_adv = 0; end
              end
            end
          end
        end
      end
      default: begin
        if (stop) begin nxt = 0; m_adv = 0; end
        else if (play) nxt = 2;
      end
    endcase
    m_st = nxt;
    notes = (m_adv / (m_div + 1)) / (m_nt + 1);
    pos = (m_len != 0) ? notes % m_len : notes % 4096;
    e = {tk, ns, (nxt == 1), 2'(nxt), 12'(pos), dn};
  endtask

  task automatic drive(input bit play, input bit pause, input bit stop,
                       input bit we, input int div, input int nt,
                       input int len, input bit loop);
    logic [17:0] e;
    @(negedge clk);
    bus.i_play = play; bus.i_pause = pause; bus.i_stop = stop;
    bus.i_cfg_we = we; bus.i_cfg_tick_div = 20'(div);
    bus.i_cfg_note_ticks = 4'(nt); bus.i_cfg_song_len = 12'(len);
    bus.i_cfg_loop = loop;
    model_step(play, pause, stop, we, div, nt, len, loop, e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic cfg(input int div, input int nt, input int len, input bit loop);
    drive(1'b0, 1'b0, 1'b0, 1'b1, div, nt, len, loop);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [17:0] a;
    a = {bus.o_tick_stb, bus.o_note_stb, bus.o_chan_rst, bus.o_state,
         bus.o_note_pos, bus.o_done};
    checks++;
    if (a !== 18'h0) begin
      errors++;
      $display("FAIL %s outputs got=%h exp=%h", name, a, 18'h0);
    end
    checks++;
    if (dut.cfg_tick_div_r !== 20'd416666) begin
      errors++;
      $display("FAIL %s tick_div got=%0d exp=%0d", name, dut.cfg_tick_div_r, 416666);
    end
  endtask

  // Monitor: one scoreboard entry per clock edge
  initial begin
    logic [17:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {bus.o_tick_stb, bus.o_note_stb, bus.o_chan_rst, bus.o_state,
             bus.o_note_pos, bus.o_done};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle t=%0t got tick=%b note=%b crst=%b st=%0d pos=%0d done=%b exp tick=%b note=%b crst=%b st=%0d pos=%0d done=%b",
                   $time, a[17], a[16], a[15], a[14:13], a[12:1], a[0],
                   e[17], e[16], e[15], e[14:13], e[12:1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [17:0] e;
    int r;
    rst_n = 1'b0;
    bus.i_play = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0;
    bus.i_cfg_we = 1'b0; bus.i_cfg_tick_div = 20'd0;
    bus.i_cfg_note_ticks = 4'd0; bus.i_cfg_song_len = 12'd0; bus.i_cfg_loop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // basic timing, no loop
    cfg(3, 1, 3, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(32);

    // looping playback, then stop
    cfg(3, 1, 3, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(58);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);

    // pause at cycle 8, resume at cycle 20
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(7);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(11);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(20);

    // config write while playing is ignored; play+stop stops
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1);
    idle(12);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    idle(3);

    // edge config: strobes every cycle, position wraps without done
    cfg(0, 0, 0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(4105);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);

    // randomized commands and configuration
    cfg(2, 1, 3, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      drive(r < 6, (r >= 6) && (r < 10), (r >= 10) && (r < 12),
            $urandom_range(0, 9) == 0, $urandom_range(0, 4),
            $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of playback
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    cfg(3, 1, 3, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(11);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.i_play = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0; bus.i_cfg_we = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    sb_q.push_back(18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, e);
    sb_q.push_back(e);
    idle(5);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_transport_ctrl.md
Name: song_transport_ctrl

Overview:
Transport controller that sequences the channel note sequencers. It generates the shared frame tick strobe (o_tick_stb) and note strobe (o_note_stb) that every channel sequencer consumes. It provides play, pause and stop control, and issues a one-cycle channel-reset pulse so all channels restart in lockstep. It also tracks song position and ends or loops playback after a configured number of note steps.

Parameters:
TICK_DIV_W, 20, width of tick divider reload
DEFAULT_TICK_DIV, 416666, reset value of tick divider (tick period = value+1 clocks)
DEFAULT_NOTE_TICKS, 7, reset value of ticks-per-note minus one
SONG_LEN_W, 12, width of song-length / position counters
DEFAULT_SONG_LEN, 0, reset song length in note steps (0 = endless)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_play  in  1  play command pulse
i_pause  in  1  pause command pulse
i_stop  in  1  stop command pulse
i_cfg_we  in  1  config write strobe
i_cfg_tick_div  in  TICK_DIV_W  tick period minus one
i_cfg_note_ticks  in  4  ticks per note step minus one
i_cfg_song_len  in  SONG_LEN_W  note steps per song pass, 0 = endless
i_cfg_loop  in  1  1 = restart position at end, 0 = stop at end
o_tick_stb  out  1  one-cycle frame tick to channels
o_note_stb  out  1  one-cycle note step to channels, always coincident with o_tick_stb
o_chan_rst  out  1  one-cycle synchronous clear to channel sequencers
o_state  out  2  0 STOPPED, 1 START, 2 PLAYING, 3 PAUSED
o_note_pos  out  SONG_LEN_W  note steps completed in current pass
o_done  out  1  one-cycle end-of-pass pulse

Behaviour:
- One clock; reset is asynchronous and active-low, on i_rst_n.
- Reset values:
  - State STOPPED.
  - tick_cnt, frame_cnt and o_note_pos are 0.
  - All strobes, o_chan_rst and o_done are 0.
  - Config registers take the DEFAULT_* values; loop = 1.
  - Reset mid-play aborts immediately; no o_done is issued.
- Config:
  - i_cfg_we latches all cfg inputs only when state is STOPPED.
  - i_cfg_we in any other state is ignored.
- Command priority within one cycle: stop > play > pause.
  - Commands that are invalid in the current state are ignored.
- Transitions (registered; the new state is visible the next cycle):
  - STOPPED + play -> START.
  - START -> PLAYING unconditionally; a stop in START -> STOPPED instead.
  - PLAYING + pause -> PAUSED.
  - PAUSED + play -> PLAYING. Counters resume from held values and no o_chan_rst is issued.
  - Any state + stop -> STOPPED. tick_cnt, frame_cnt and o_note_pos clear; strobes are suppressed that cycle.
- START state:
  - o_chan_rst = 1 for exactly that one cycle.
  - tick_cnt, frame_cnt and o_note_pos are cleared.
- Tick generation, in PLAYING with no stop or pause this cycle ("advancing"):
  - If tick_cnt == tick_div, then tick_cnt <= 0 and o_tick_stb <= 1 (registered).
  - Otherwise tick_cnt increments.
  - tick_div = 0 gives o_tick_stb every cycle.
- Note generation, evaluated on each tick condition:
  - If frame_cnt == note_ticks, then frame_cnt <= 0, o_note_stb <= 1, and o_note_pos increments.
  - Otherwise frame_cnt increments.
- End of pass: at a note event where song_len != 0 and o_note_pos == song_len-1:
  - o_done <= 1, registered coincident with that o_note_stb.
  - o_note_pos <= 0.
  - If loop = 1, stay in PLAYING.
  - If loop = 0, state <= STOPPED at the same edge.
- song_len = 0: never ends. o_note_pos wraps modulo 2^SONG_LEN_W with no o_done.
- Pause or stop on the terminal tick cycle: no strobe is generated and counters hold (pause) or clear (stop).
- PAUSED and STOPPED: all strobes are 0.

Test Plan:
- Basic timing. Config tick_div=3, note_ticks=1, song_len=3, loop=0; play at cycle 0.
  - o_chan_rst at cycle 1; PLAYING from cycle 2.
  - o_tick_stb at cycles 6, 10, 14, 18, 22, 26.
  - o_note_stb at 10, 18, 26, with o_note_pos 1, 2, then 0.
  - o_done at 26; o_state=STOPPED from 26.
- Loop. Same config with loop=1.
  - o_done at 26 and 50.
  - Playback continues; no o_chan_rst after cycle 1.
- Pause/resume. Pause at cycle 8, play at cycle 20.
  - Strobes are absent during PAUSED.
  - First tick after resume arrives 2 cycles after PLAYING re-entry (tick_cnt held at 2).
  - No o_chan_rst on resume.
- Priority. Assert play+stop in the same cycle from PLAYING → STOPPED, counters 0.
  - Config write while PLAYING (tick_div=0) → ignored; tick period stays 4.
- Edge config. tick_div=0, note_ticks=0, song_len=0.
  - o_tick_stb and o_note_stb every cycle in PLAYING.
  - o_note_pos wraps from 4095 to 0 with no o_done.
- Async reset. Assert i_rst_n low mid-PLAYING, between clock edges.
  - Outputs go to 0 immediately, state STOPPED, config back to defaults (tick_div=416666).
